// File: rtl/bridge_timer_if.sv
// Processor-bus bundle between the CPU datapath M stage and the timer bridge.
// Single-cycle bus with no valid/ready: a write commits on the rising edge where PrWe=1, and PrRD is combinational on PrAddr.
interface bridge_timer_if;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWe;
    logic [31:0] PrRD;

    modport master (output PrAddr, output PrWD, output PrWe, input PrRD);
    modport slave  (input PrAddr, input PrWD, input PrWe, output PrRD);
endinterface

// File: rtl/bridge_timer.sv
// Processor-bus bridge with two count-down timers (timer0, timer1) and the HWInt merge for CP0.
// timer_state exposes both FSM states as {timer1, timer0}.
module bridge_timer #(
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10
) (
    input  logic                 clk,
    input  logic                 reset,
    bridge_timer_if.slave        bus,
    input  logic [3:0]           ExtInt,
    output logic [7:2]           HWInt,
    output logic [3:0]           timer_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    logic [31:0] rd_data [2];
    logic [1:0]  st      [2];
    logic [1:0]  irq;
    logic        unused_addr;

    assign unused_addr = &{1'b0, bus.PrAddr[31:16], bus.PrAddr[1:0]};

    for (genvar i = 0; i < 2; i++) begin : g_timer
        localparam logic [31:0] BASE = (i == 0) ? TIMER0_BASE : TIMER1_BASE;

        logic        hit;
        logic        ctrl_we;
        logic        preset_we;
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        logic        pending;
        state_t      state;
        state_t      state_next;
        logic [31:0] count_next;
        logic        pending_next;
        logic        en_clear;

        assign hit       = (bus.PrAddr[15:4] == BASE[15:4]);
        assign ctrl_we   = bus.PrWe && hit && (bus.PrAddr[3:2] == 2'd0);
        assign preset_we = bus.PrWe && hit && (bus.PrAddr[3:2] == 2'd1);

        always_comb begin
            state_next   = state;
            count_next   = count;
            pending_next = pending;
            en_clear     = 1'b0;
            case (state)
                IDLE: if (ctrl[0]) state_next = LOAD;
                LOAD: begin
                    count_next = preset;
                    state_next = CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state_next = IDLE;
                    end else if (count > 32'd1) begin
                        count_next = count - 32'd1;
                    end else begin
                        count_next   = '0;
                        pending_next = 1'b1;
                        state_next   = INT;
                    end
                end
                INT: begin
                    // MODE 1x behaves as one-shot, so only 01 reloads
                    if (ctrl[2:1] == 2'b01) begin
                        pending_next = 1'b0;
                        state_next   = LOAD;
                    end else begin
                        en_clear   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (ctrl_we) pending_next = 1'b0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                ctrl    <= '0;
                preset  <= '0;
                count   <= '0;
                pending <= 1'b0;
            end else begin
                state   <= state_next;
                count   <= count_next;
                pending <= pending_next;
                // A CPU CTRL write takes priority over the one-shot EN clear
                if (ctrl_we) begin
                    ctrl <= bus.PrWD[3:0];
                end else if (en_clear) begin
                    ctrl[0] <= 1'b0;
                end
                if (preset_we) preset <= bus.PrWD;
            end
        end

        always_comb begin
            rd_data[i] = '0;
            if (hit) begin
                case (bus.PrAddr[3:2])
                    2'd0:    rd_data[i] = {28'd0, ctrl};
                    2'd1:    rd_data[i] = preset;
                    2'd2:    rd_data[i] = count;
                    default: rd_data[i] = '0;
                endcase
            end
        end

        assign irq[i] = pending & ctrl[3];
        assign st[i]  = state;
    end

    assign bus.PrRD    = rd_data[0] | rd_data[1];
    assign HWInt       = {ExtInt, irq};
    assign timer_state = {st[1], st[0]};

endmodule

// File: doc/bridge_timer.md
Name: bridge_timer

Overview:
- Peripheral-side block directly downstream of the CPU datapath's processor bus.
- Consumes PrAddr/PrWD/PrWe from the datapath's M stage and returns PrRD plus the 6-bit HWInt vector that feeds CP0.
- Contains the address decode for two identical programmable count-down timers (timer0, timer1), each with its own register file, FSM and interrupt line.
- External interrupt sources are merged into HWInt.

Parameters:
- TIMER0_BASE, 32'h0000_7F00, base address of timer0; decode compares PrAddr[15:4].
- TIMER1_BASE, 32'h0000_7F10, base address of timer1; same decode.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- PrAddr  in  32  processor bus address (word access; PrAddr[1:0] ignored).
- PrWD  in  32  processor bus write data.
- PrWe  in  1  processor bus write enable.
- PrRD  out  32  processor bus read data, combinational.
- ExtInt  in  4  external interrupt lines, passed to HWInt[7:4].
- HWInt  out  6  interrupt vector [7:2]: [2]=timer0 irq, [3]=timer1 irq, [7:4]=ExtInt.

Behaviour:
- Register map per timer (offset = PrAddr[3:2]):
  - 0 CTRL, R/W: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (irq mask); bits[31:4] read 0.
  - 1 PRESET, R/W.
  - 2 COUNT, read-only; writes ignored.
  - 3 unmapped: read 0, write ignored.
- Address decode:
  - Hit on timer i when PrAddr[15:4]==BASE_i[15:4].
  - No hit: PrRD=0; writes ignored.
  - Writes occur on the clock edge when PrWe=1 and the address hits.
- Reset (async, reset=0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, so HWInt[3:2]=0. Takes effect immediately, including mid-count. HWInt[7:4] always follows ExtInt combinationally.
- FSM states, per timer: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT, EN=0: -> IDLE; COUNT holds.
  - CNT, COUNT>1: COUNT<=COUNT-1, stay.
  - CNT, COUNT<=1 (includes PRESET=0): COUNT<=0, pending<=1 -> INT.
  - INT, MODE=00: EN<=0, -> IDLE; pending holds.
  - INT, MODE=01: pending<=0, -> LOAD.
- Timing: with CTRL written EN=1 at edge t and PRESET=N>=1:
  - LOAD at t+1; COUNT=N after t+2.
  - COUNT=1 after t+N+1; INT entered at edge t+N+2.
- irq_i = pending & IM, registered-state-derived, with no combinational path from PrWD.
  - MODE 00: irq stays high until any CTRL write, which clears pending.
  - MODE 01: irq is high exactly one cycle (the INT cycle), repeating every N+2 cycles.
- Any CTRL write clears pending, whatever the value written.
- Simultaneous CPU CTRL write and FSM EN clear (INT, MODE 00): the CPU write wins; the FSM goes to IDLE, then restarts via LOAD if the written EN=1.
- PRESET writes during CNT do not affect the running COUNT; they take effect at the next LOAD.
- A CTRL write with EN=1 while in CNT keeps counting, with no reload.
- Arithmetic: 32-bit unsigned; COUNT never wraps below 0.
- Read/write same cycle: PrRD returns the pre-edge value.

Test Plan:
- Reset values: assert reset=0 mid-count (COUNT=5) -> COUNT, CTRL, PRESET read 0 immediately; HWInt=={ExtInt,2'b00}.
- One-shot: timer0 PRESET=3, CTRL=0x9 -> COUNT reads 3,2,1 on consecutive cycles, then 0; HWInt[2] rises 5 cycles after the CTRL write edge and holds; CTRL reads 0x8; writing CTRL=0x8 clears HWInt[2] next cycle.
- Auto-reload: timer1 at 0x7F10, PRESET=2, CTRL=0xB -> HWInt[3] one-cycle pulses every 4 cycles, for 3 pulses; COUNT reloads to 2 after each pulse.
- Mask/disable: PRESET=4, CTRL=0x1 (IM=0) -> HWInt[2] stays 0 while COUNT reaches 0. Separately, CTRL=0x0 written at COUNT=2 -> COUNT freezes at 2, state IDLE.
- Decode: write 0x1234 to 0x7F0C, 0x7F20 and 0x7F08 -> no register changes, reads 0; read 0x7F04 after a PRESET write of 0xDEAD returns 0xDEAD.
- Boundary: PRESET=0, CTRL=0x9 -> INT reached 3 cycles after the write edge; ExtInt=4'b1010 -> HWInt[7:4]=4'b1010 the same cycle.
